// File: rtl/condicionador_botao.sv
// -----------------------------------------------------------------------------
// condicionador_botao
//
// Pedestrian push-button conditioner that feeds the `bt` input of the
// `semaforo` traffic-light controller.
//
// The raw button goes through a two-flop synchroniser and then a debouncer.
// Each accepted rising edge of the debounced level is a press. A press moves
// the FSM from idle into a request state. The request is held on `bt` until
// controller output A enters its red phase. After the crossing has been
// served, further presses are locked out for LOCKOUT cycles. Accepted presses
// are counted in a saturating 8-bit counter for monitoring.
//
// Parameters
//   DEBOUNCE      number of consecutive synchronised cycles a level change
//                 must persist before it is accepted (1..255; 0 acts as 1)
//   LOCKOUT       number of cycles presses are ignored after a serve (0..255)
//   COD_VERMELHO  code on A meaning "semaphore A is red" (pedestrians go)
//
// Ports
//   clk        in   1  single clock; all state changes on its rising edge
//   rst        in   1  asynchronous, active-low reset
//   bt_raw     in   1  raw, asynchronous, bouncing push-button
//   A          in   3  current state output of the semaforo
//   bt         out  1  registered pedestrian request to the semaforo
//   press_cnt  out  8  accepted presses, saturating at 255
// -----------------------------------------------------------------------------
module condicionador_botao #(
    parameter logic [7:0] DEBOUNCE     = 8'd3,
    parameter logic [7:0] LOCKOUT      = 8'd4,
    parameter logic [2:0] COD_VERMELHO = 3'b001
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bt_raw,
    input  logic [2:0] A,
    output logic       bt,
    output logic [7:0] press_cnt
);

    // -------------------------------------------------------------------------
    // FSM encoding
    // -------------------------------------------------------------------------
    localparam logic [1:0] OCIOSO   = 2'd0;  // idle, waiting for a press
    localparam logic [1:0] PEDIDO   = 2'd1;  // request pending, bt = 1
    localparam logic [1:0] ATENDIDO = 2'd2;  // served, waiting for A to leave red
    localparam logic [1:0] BLOQUEIO = 2'd3;  // post-serve lockout

    // Terminal value of the debounce counter. A DEBOUNCE of 0 behaves like 1,
    // i.e. the change is accepted on the first cycle it is seen at s2.
    localparam logic [7:0] DEB_LAST  = (DEBOUNCE == 8'd0) ? 8'd0 : DEBOUNCE - 8'd1;

    // Lockout counter start value. Loading LOCKOUT-1 and leaving when the
    // counter reads 0 keeps the FSM in BLOQUEIO for exactly LOCKOUT cycles.
    // Only used when LOCKOUT != 0.
    localparam logic [7:0] LOCK_LAST = LOCKOUT - 8'd1;

    // -------------------------------------------------------------------------
    // Internal signals
    // -------------------------------------------------------------------------
    logic       s1;             // first synchroniser stage
    logic       s2;             // second synchroniser stage (safe to use)
    logic       db;             // debounced button level
    logic [7:0] dcnt;           // debounce persistence counter
    logic [2:0] a_prev;         // A delayed by one cycle, for red-entry detect
    logic [1:0] state;
    logic [7:0] lcnt;           // lockout down-counter

    logic       deb_hit;        // s2 differs from db and has persisted long enough
    logic       press;          // db is about to go 0 -> 1
    logic       a_red;          // A currently shows the red code
    logic       serve;          // first cycle of a red phase on A

    logic [1:0] state_nxt;
    logic [7:0] lcnt_nxt;
    logic       cnt_inc;        // count this press

    // -------------------------------------------------------------------------
    // Two-flop synchroniser for the asynchronous button
    // -------------------------------------------------------------------------
    // NOTE: sequential state is always written with non-blocking assignments so
    // every flop samples the pre-edge value of the others; with blocking
    // assignments s2 would pick up bt_raw in the same edge and the chain would
    // collapse into a single stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= bt_raw;
            s2 <= s1;
        end
    end

    // -------------------------------------------------------------------------
    // Debouncer
    //
    // dcnt counts how many consecutive cycles s2 has disagreed with db. Any
    // cycle where s2 falls back to db restarts the count, so a glitch never
    // accumulates. When the disagreement has lasted DEBOUNCE cycles the new
    // level is taken into db.
    // -------------------------------------------------------------------------
    assign deb_hit = (s2 != db) && (dcnt == DEB_LAST);

    // A press is the accepted 0 -> 1 change of db, flagged in the same cycle
    // the update condition holds so the FSM moves on the same edge as db.
    // The 1 -> 0 (release) change produces no event.
    assign press   = deb_hit && s2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db   <= 1'b0;
            dcnt <= 8'd0;
        end else if (s2 == db) begin
            dcnt <= 8'd0;
        end else if (deb_hit) begin
            db   <= s2;
            dcnt <= 8'd0;
        end else begin
            dcnt <= dcnt + 8'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Serve detection
    //
    // a_prev resets to the red code so that A already being red when reset
    // is released does not look like a fresh red phase.
    // -------------------------------------------------------------------------
    assign a_red = (A == COD_VERMELHO);
    assign serve = a_red && (a_prev != COD_VERMELHO);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_prev <= COD_VERMELHO;
        end else begin
            a_prev <= A;
        end
    end

    // -------------------------------------------------------------------------
    // Request FSM: next-state logic
    //
    // Because serve only fires on the entry into red, a press accepted while
    // A is already red stays pending through the current red phase and is
    // served by the next one.
    // -------------------------------------------------------------------------
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        lcnt_nxt  = lcnt;
        cnt_inc   = 1'b0;

        case (state)
            OCIOSO: begin
                if (press) begin
                    state_nxt = PEDIDO;
                    cnt_inc   = 1'b1;
                end
            end

            PEDIDO: begin
                // Additional presses merge into the pending request.
                if (serve) begin
                    state_nxt = ATENDIDO;
                end
            end

            ATENDIDO: begin
                if (!a_red) begin
                    if (LOCKOUT == 8'd0) begin
                        state_nxt = OCIOSO;
                    end else begin
                        state_nxt = BLOQUEIO;
                        lcnt_nxt  = LOCK_LAST;
                    end
                end
            end

            BLOQUEIO: begin
                // Presses are ignored here, including one accepted on the
                // exit edge itself.
                if (lcnt == 8'd0) begin
                    state_nxt = OCIOSO;
                end else begin
                    lcnt_nxt = lcnt - 8'd1;
                end
            end

            default: begin
                state_nxt = OCIOSO;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Request FSM: registers
    //
    // bt is its own flop, loaded from the next-state decode, so it always
    // equals (state == PEDIDO) while remaining a clean register output.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= OCIOSO;
            lcnt      <= 8'd0;
            bt        <= 1'b0;
            press_cnt <= 8'd0;
        end else begin
            state <= state_nxt;
            lcnt  <= lcnt_nxt;
            bt    <= (state_nxt == PEDIDO);
            if (cnt_inc && (press_cnt != 8'hFF)) begin
                press_cnt <= press_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_condicionador_botao.sv
// -----------------------------------------------------------------------------
// tb_condicionador_botao
//
// Directed bench for condicionador_botao. The main instance uses
// DEBOUNCE=3, LOCKOUT=4, COD_VERMELHO=001. A second instance with LOCKOUT=0
// is used for the press-counter saturation run.
//
// Timing reference used for the expected values: with bt_raw set just after
// an edge, the next edge (1) loads s1, edge 2 loads s2, edges 3 and 4 count
// the debounce and edge 5 accepts the press, so bt rises after edge 5.
// -----------------------------------------------------------------------------
module tb_condicionador_botao;

    logic       clk;
    logic       rst;
    logic       bt_raw;
    logic [2:0] a_in;
    logic       bt;
    logic [7:0] press_cnt;

    logic       bt_raw_s;
    logic [2:0] a_s;
    logic       bt_s;
    logic [7:0] press_cnt_s;

    int n_cmp;
    int n_err;

    localparam logic [2:0] RED    = 3'b001;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b100;

    condicionador_botao #(
        .DEBOUNCE    (8'd3),
        .LOCKOUT     (8'd4),
        .COD_VERMELHO(3'b001)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bt_raw   (bt_raw),
        .A        (a_in),
        .bt       (bt),
        .press_cnt(press_cnt)
    );

    condicionador_botao #(
        .DEBOUNCE    (8'd3),
        .LOCKOUT     (8'd0),
        .COD_VERMELHO(3'b001)
    ) dut_sat (
        .clk      (clk),
        .rst      (rst),
        .bt_raw   (bt_raw_s),
        .A        (a_s),
        .bt       (bt_s),
        .press_cnt(press_cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        rst      = 1'b0;
        bt_raw   = 1'b0;
        a_in     = GREEN;
        bt_raw_s = 1'b0;
        a_s      = GREEN;
        tick(2);
        rst = 1'b1;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        rst      = 1'b0;
        bt_raw   = 1'b1;
        a_in     = RED;
        bt_raw_s = 1'b0;
        a_s      = GREEN;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            n_cmp++;
            if (bt !== 1'b0) begin
                n_err++;
                $display("FAIL reset_bt cycle %0d: got %b expected 0", i, bt);
            end
            n_cmp++;
            if (press_cnt !== 8'd0) begin
                n_err++;
                $display("FAIL reset_cnt cycle %0d: got %0d expected 0", i, press_cnt);
            end
        end
        rst  = 1'b1;
        a_in = GREEN;
        tick(4);
        n_cmp++;
        if (bt !== 1'b0) begin
            n_err++;
            $display("FAIL reset_latency_early: got %b expected 0 after edge 4", bt);
        end
        tick(1);
        n_cmp++;
        if (bt !== 1'b1) begin
            n_err++;
            $display("FAIL reset_latency_bt: got %b expected 1 after edge 5", bt);
        end
        n_cmp++;
        if (press_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL reset_latency_cnt: got %0d expected 1", press_cnt);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_bounce();
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            bt_raw = (i % 2 == 0);
            tick(1);
            n_cmp++;
            if (bt !== 1'b0) begin
                n_err++;
                $display("FAIL bounce_toggle cycle %0d: got %b expected 0", i, bt);
            end
        end
        bt_raw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            n_cmp++;
            if (bt !== 1'b0) begin
                n_err++;
                $display("FAIL bounce_settle cycle %0d: got %b expected 0", i, bt);
            end
        end
        n_cmp++;
        if (press_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL bounce_cnt: got %0d expected 0", press_cnt);
        end
        // Two-cycle pulse: one short of the debounce time.
        bt_raw = 1'b1;
        tick(2);
        bt_raw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            n_cmp++;
            if (bt !== 1'b0) begin
                n_err++;
                $display("FAIL short_pulse cycle %0d: got %b expected 0", i, bt);
            end
        end
        n_cmp++;
        if (press_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL short_pulse_cnt: got %0d expected 0", press_cnt);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_serve_lockout();
        bt_raw = 1'b1;
        tick(4);
        n_cmp++;
        if (bt !== 1'b0) begin
            n_err++;
            $display("FAIL serve_press_early: got %b expected 0", bt);
        end
        tick(1);
        n_cmp++;
        if (bt !== 1'b1 || press_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL serve_press: got bt=%b cnt=%0d expected bt=1 cnt=1", bt, press_cnt);
        end
        bt_raw = 1'b0;
        tick(6);
        a_in = YELLOW;
        tick(1);
        n_cmp++;
        if (bt !== 1'b1) begin
            n_err++;
            $display("FAIL serve_hold_yellow: got %b expected 1", bt);
        end
        a_in = RED;
        tick(1);
        n_cmp++;
        if (bt !== 1'b0) begin
            n_err++;
            $display("FAIL serve_fall: got %b expected 0 on first red edge", bt);
        end
        tick(1);
        // Button goes up during the last red cycle; it is accepted on the
        // third lockout edge and must be ignored.
        bt_raw = 1'b1;
        tick(1);
        a_in = GREEN;
        for (int i = 0; i < 7; i++) begin
            tick(1);
            n_cmp++;
            if (bt !== 1'b0) begin
                n_err++;
                $display("FAIL lockout_bt edge %0d: got %b expected 0", i, bt);
            end
        end
        n_cmp++;
        if (press_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL lockout_cnt: got %0d expected 1", press_cnt);
        end
        bt_raw = 1'b0;
        tick(6);
        bt_raw = 1'b1;
        tick(4);
        n_cmp++;
        if (bt !== 1'b0) begin
            n_err++;
            $display("FAIL post_lockout_early: got %b expected 0", bt);
        end
        tick(1);
        n_cmp++;
        if (bt !== 1'b1 || press_cnt !== 8'd2) begin
            n_err++;
            $display("FAIL post_lockout_press: got bt=%b cnt=%0d expected bt=1 cnt=2", bt, press_cnt);
        end
        bt_raw = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_press_during_red();
        // Serve the pending request and run out the lockout.
        a_in = RED;
        tick(1);
        a_in = GREEN;
        tick(20);
        n_cmp++;
        if (bt !== 1'b0) begin
            n_err++;
            $display("FAIL red_idle: got %b expected 0", bt);
        end
        a_in = RED;
        tick(2);
        bt_raw = 1'b1;
        tick(5);
        n_cmp++;
        if (bt !== 1'b1 || press_cnt !== 8'd3) begin
            n_err++;
            $display("FAIL red_press: got bt=%b cnt=%0d expected bt=1 cnt=3", bt, press_cnt);
        end
        bt_raw = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            n_cmp++;
            if (bt !== 1'b1) begin
                n_err++;
                $display("FAIL red_hold cycle %0d: got %b expected 1", i, bt);
            end
        end
        a_in = GREEN;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            n_cmp++;
            if (bt !== 1'b1) begin
                n_err++;
                $display("FAIL red_hold_green cycle %0d: got %b expected 1", i, bt);
            end
        end
        a_in = RED;
        tick(1);
        n_cmp++;
        if (bt !== 1'b0) begin
            n_err++;
            $display("FAIL red_next_serve: got %b expected 0", bt);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_merge();
        a_in   = GREEN;
        bt_raw = 1'b0;
        tick(20);
        bt_raw = 1'b1;
        tick(5);
        n_cmp++;
        if (bt !== 1'b1 || press_cnt !== 8'd4) begin
            n_err++;
            $display("FAIL merge_first: got bt=%b cnt=%0d expected bt=1 cnt=4", bt, press_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            bt_raw = 1'b0;
            tick(6);
            bt_raw = 1'b1;
            tick(6);
        end
        n_cmp++;
        if (bt !== 1'b1 || press_cnt !== 8'd4) begin
            n_err++;
            $display("FAIL merge_cnt: got bt=%b cnt=%0d expected bt=1 cnt=4", bt, press_cnt);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_saturation();
        logic [7:0] exp_cnt;
        exp_cnt = 8'd0;
        for (int i = 0; i < 258; i++) begin
            bt_raw_s = 1'b1;
            tick(5);
            if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
            n_cmp++;
            if (bt_s !== 1'b1 || press_cnt_s !== exp_cnt) begin
                n_err++;
                $display("FAIL sat_press %0d: got bt=%b cnt=%0d expected bt=1 cnt=%0d",
                         i, bt_s, press_cnt_s, exp_cnt);
            end
            bt_raw_s = 1'b0;
            a_s      = RED;
            tick(1);
            a_s      = GREEN;
            tick(5);
        end
        n_cmp++;
        if (press_cnt_s !== 8'd255) begin
            n_err++;
            $display("FAIL sat_final: got %0d expected 255", press_cnt_s);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset_mid();
        @(posedge clk);
        #3;
        rst    = 1'b0;
        bt_raw = 1'b0;
        #1;
        n_cmp++;
        if (bt !== 1'b0 || press_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL reset_mid_async: got bt=%b cnt=%0d expected bt=0 cnt=0", bt, press_cnt);
        end
        tick(1);
        rst = 1'b1;
        n_cmp++;
        if (bt !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_hold: got %b expected 0", bt);
        end
        bt_raw = 1'b1;
        tick(4);
        n_cmp++;
        if (bt !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_early: got %b expected 0", bt);
        end
        tick(1);
        n_cmp++;
        if (bt !== 1'b1 || press_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL reset_mid_press: got bt=%b cnt=%0d expected bt=1 cnt=1", bt, press_cnt);
        end
    endtask

    // -------------------------------------------------------------------------
    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_bounce();
        test_serve_lockout();
        test_press_during_red();
        test_merge();
        test_saturation();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
